alert_frame_tx: RTL

//  Consumes alert events from the safety core (alert_level, power_mode) and

---
 rtl/alert_frame_tx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/alert_frame_tx.sv
// Alert event framer: 4-byte 8N1 UART packets with a merging pending slot.
// Frame = SOF, {mode,level}, seq, XOR checksum; one DONE cycle between frames.
module alert_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  SOF_BYTE     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alert_valid,
  input  logic [1:0] alert_level,
  input  logic [2:0] power_mode,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] seq_num,
  output logic [7:0] merge_cnt
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_idx;
  logic [1:0]    r_byte_idx;

  logic [1:0] r_lvl;
  logic [2:0] r_mode;
  logic [7:0] r_seq;

  logic       r_pend_full;
  logic [1:0] r_pend_lvl;
  logic [2:0] r_pend_mode;
  logic [7:0] r_merge_cnt;

  logic       w_tick;
  logic       w_in_bit;
  logic [7:0] w_b1;
  logic [7:0] w_b3;
  logic [7:0] w_byte;
  logic [1:0] w_max_lvl;
  logic [7:0] w_merge_inc;

  assign w_tick      = (r_timer == LAST_TICK);
  assign w_in_bit    = (r_state == S_START) ||
                       (r_state == S_DATA)  ||
                       (r_state == S_STOP);
  assign w_b1        = {3'b000, r_mode, r_lvl};
  assign w_b3        = SOF_BYTE ^ w_b1 ^ r_seq;
  assign w_max_lvl   = (alert_level > r_pend_lvl) ?
                       alert_level : r_pend_lvl;
  assign w_merge_inc = (r_merge_cnt == 8'hFF) ?
                       r_merge_cnt : r_merge_cnt + 8'd1;

  assign seq_num   = r_seq;
  assign merge_cnt = r_merge_cnt;

  // Select the frame byte currently on the wire
  always_comb begin
    w_byte = SOF_BYTE;
    unique case (r_byte_idx)
      2'd0: w_byte = SOF_BYTE;
      2'd1: w_byte = w_b1;
      2'd2: w_byte = r_seq;
      2'd3: w_byte = w_b3;
      default: w_byte = SOF_BYTE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and line/status outputs; line idles high outside bits
  always_comb begin
    w_next     = r_state;
    tx_out     = 1'b1;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (alert_valid) begin
          w_next = S_START;
        end
      end
      S_START: begin
        tx_out = 1'b0;
        if (w_tick) begin
          w_next = S_DATA;
        end
      end
      S_DATA: begin
        tx_out = w_byte[r_bit_idx];
        if (w_tick && (r_bit_idx == 3'd7)) begin
          w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_next = (r_byte_idx == 2'd3) ? S_DONE : S_START;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        // An event arriving in this very cycle still chains back-to-back
        w_next = (r_pend_full || alert_valid) ? S_START : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
        busy   = 1'b0;
      end
    endcase
  end

  // Bit timer, bit index and byte index, advanced only by the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer    <= '0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= 2'd0;
    end else begin
      if (w_in_bit) begin
        r_timer <= w_tick ? '0 : r_timer + TW'(1);
      end else begin
        r_timer <= '0;
      end
      if ((r_state == S_DATA) && w_tick) begin
        r_bit_idx <= (r_bit_idx == 3'd7) ? 3'd0 : r_bit_idx + 3'd1;
      end
      if ((r_state == S_STOP) && w_tick) begin
        r_byte_idx <= (r_byte_idx == 2'd3) ? 2'd0 : r_byte_idx + 2'd1;
      end else if (!w_in_bit) begin
        r_byte_idx <= 2'd0;
      end
    end
  end

  // In-flight fields, sequence number, pending slot and merge counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lvl       <= 2'd0;
      r_mode      <= 3'd0;
      r_seq       <= 8'd0;
      r_pend_full <= 1'b0;
      r_pend_lvl  <= 2'd0;
      r_pend_mode <= 3'd0;
      r_merge_cnt <= 8'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (alert_valid) begin
            r_lvl  <= alert_level;
            r_mode <= power_mode;
          end
        end
        S_DONE: begin
          r_seq       <= r_seq + 8'd1;
          r_pend_full <= 1'b0;
          if (alert_valid) begin
            r_lvl  <= r_pend_full ? w_max_lvl : alert_level;
            r_mode <= power_mode;
            if (r_pend_full) begin
              r_merge_cnt <= w_merge_inc;
            end
          end else if (r_pend_full) begin
            r_lvl  <= r_pend_lvl;
            r_mode <= r_pend_mode;
          end
        end
        default: begin
          if (alert_valid) begin
            r_pend_full <= 1'b1;
            r_pend_lvl  <= r_pend_full ? w_max_lvl : alert_level;
            r_pend_mode <= power_mode;
            if (r_pend_full) begin
              r_merge_cnt <= w_merge_inc;
            end
          end
        end
      endcase
    end
  end

endmodule
